// File: rtl/debug_page_controller_pkg.sv
// debug_page_controller_pkg: shared FSM encoding and page geometry for the debug page controller.
package debug_page_controller_pkg;
   typedef enum logic {ST_MANUAL = 1'b0, ST_AUTO = 1'b1} state_t;
   localparam int PAGE_W    = 2;
   localparam int PAGE_BITS = 32;
   localparam int NUM_PAGES = 4;
endpackage

// File: rtl/debug_page_controller_key_debouncer.sv
// key_debouncer: synchronizes an active-low raw button and emits a debounced level plus a press pulse.
module key_debouncer #(
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_key_n,
   output logic o_level,
   output logic o_press
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   logic [1:0]    r_sync;
   logic [CW-1:0] r_cnt;
   logic          r_level;
   logic          r_press;
   logic          w_diff;
   logic          w_done;
   // r_sync and r_level carry pressed-high polarity so reset means released
   assign w_diff = r_sync[1] ^ r_level;
   assign w_done = w_diff && (r_cnt == CW'(DEBOUNCE_CYCLES - 1));
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync  <= '0;
         r_cnt   <= '0;
         r_level <= 1'b0;
         r_press <= 1'b0;
      end else begin
         r_sync  <= {r_sync[0], ~i_key_n};
         r_cnt   <= (w_diff && !w_done) ? r_cnt + 1'b1 : '0;
         r_level <= r_level ^ w_done;
         r_press <= w_done && !r_level;
      end
   end
   assign o_level = r_level;
   assign o_press = r_press;
endmodule

// File: rtl/debug_page_controller.sv
// debug_page_controller: pages the 128-bit debug bus onto a 32-bit display word
// with debounced next/mode/hold buttons and a manual/auto-rotate FSM.
module debug_page_controller
   import debug_page_controller_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int DWELL_CYCLES    = 50000000
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          key_next_n,
   input  logic                          key_mode_n,
   input  logic                          key_hold_n,
   input  logic [PAGE_BITS*NUM_PAGES-1:0] debug,
   output logic [PAGE_BITS-1:0]          state_value,
   output logic [PAGE_W-1:0]             page,
   output logic                          auto_mode,
   output logic                          page_strobe
);
   localparam int DW = $clog2(DWELL_CYCLES + 1);
   state_t                         r_state, w_state_nxt;
   logic [PAGE_W-1:0]              r_page, w_page_nxt;
   logic [DW-1:0]                  r_dwell, w_dwell_nxt;
   logic [PAGE_BITS*NUM_PAGES-1:0] r_snap;
   logic [PAGE_BITS-1:0]           r_value;
   logic                           r_chg, r_strobe;
   logic                           w_expire, w_adv;
   logic                           w_next_evt, w_mode_evt, w_hold_lvl;
   logic                           w_next_lvl, w_mode_lvl, w_hold_evt;
   logic                           w_unused;
   key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next (
      .clk(clk), .rst_n(rst_n), .i_key_n(key_next_n), .o_level(w_next_lvl), .o_press(w_next_evt));
   key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode (
      .clk(clk), .rst_n(rst_n), .i_key_n(key_mode_n), .o_level(w_mode_lvl), .o_press(w_mode_evt));
   key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_hold (
      .clk(clk), .rst_n(rst_n), .i_key_n(key_hold_n), .o_level(w_hold_lvl), .o_press(w_hold_evt));
   assign w_unused = &{w_next_lvl, w_mode_lvl, w_hold_evt};
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_MANUAL;
      else        r_state <= w_state_nxt;
   end
   // a next event and a dwell expiry landing together still advance only once
   always_comb begin
      w_expire    = (r_state == ST_AUTO) && (r_dwell == DW'(DWELL_CYCLES - 1));
      w_adv       = w_next_evt || w_expire;
      w_state_nxt = w_mode_evt ? ((r_state == ST_AUTO) ? ST_MANUAL : ST_AUTO) : r_state;
      w_page_nxt  = r_page + PAGE_W'(w_adv);
      w_dwell_nxt = (r_state == ST_MANUAL || w_mode_evt || w_adv) ? '0 : r_dwell + 1'b1;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_page   <= '0;
         r_dwell  <= '0;
         r_chg    <= 1'b0;
         r_strobe <= 1'b0;
         r_snap   <= '0;
         r_value  <= '0;
      end else begin
         r_page   <= w_page_nxt;
         r_dwell  <= w_dwell_nxt;
         r_chg    <= w_adv;
         r_strobe <= r_chg;
         if (!w_hold_lvl) r_snap <= debug;
         r_value  <= r_snap[PAGE_BITS*r_page +: PAGE_BITS];
      end
   end
   assign state_value = r_value;
   assign page        = r_page;
   assign auto_mode   = (r_state == ST_AUTO);
   assign page_strobe = r_strobe;
endmodule

// File: tb/tb_debug_page_controller.sv
// tb_debug_page_controller: directed and randomized checks of paging, debounce, auto-rotate, hold and reset.
module tb_debug_page_controller;
   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [2:0]   keys_n = 3'b111;
   logic [127:0] debug = '0;
   logic [31:0]  state_value;
   logic [1:0]   page;
   logic         auto_mode;
   logic         page_strobe;
   int           n_chk = 0, n_fail = 0, n_cyc = 0, n_strobe = 0, last_chg = 0;
   int           m_page = 0, lat = 0, s0 = 0, c0 = 0, t0 = 0;
   logic [1:0]   last_page = '0, p0 = '0;
   logic         changed_last = 1'b0;
   logic [127:0] m_snap = '0, m_a = '0;
   logic         m_hold = 1'b0;
   localparam logic [127:0] K = 128'h00112233_44556677_8899AABB_CCDDEEFF;
   always #5 clk = ~clk;
   debug_page_controller #(.DEBOUNCE_CYCLES(4), .DWELL_CYCLES(8)) dut (
      .clk(clk), .rst_n(rst_n), .key_next_n(keys_n[0]), .key_mode_n(keys_n[1]),
      .key_hold_n(keys_n[2]), .debug(debug), .state_value(state_value), .page(page),
      .auto_mode(auto_mode), .page_strobe(page_strobe));
   function automatic logic [31:0] word(input int p);
      return m_snap[32*(p%4) +: 32];
   endfunction
   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_chk++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask
   // every cycle: a strobe must follow a page change and show the new page's word
   task automatic tick;
      @(posedge clk);
      #1;
      n_cyc++;
      if (page_strobe) begin
         n_strobe++;
         chk("strobe_follows_change", {127'b0, changed_last}, 128'd1);
         chk("strobe_value", {96'b0, state_value}, {96'b0, word(int'(page))});
      end
      changed_last = (page !== last_page);
      if (changed_last) last_chg = n_cyc;
      last_page = page;
   endtask
   task automatic ticks(input int n);
      repeat (n) tick();
   endtask
   task automatic set_debug(input logic [127:0] v);
      debug = v;
      if (!m_hold) m_snap = v;
   endtask
   task automatic wait_change(input string tag);
      int k = 0;
      logic [1:0] p = page;
      while (page === p && k < 24) begin
         tick();
         k++;
      end
      chk(tag, {127'b0, page !== p}, 128'd1);
   endtask
   task automatic wait_auto(input logic exp, input string tag);
      int k = 0;
      while (auto_mode !== exp && k < 24) begin
         tick();
         k++;
      end
      chk(tag, {127'b0, auto_mode}, {127'b0, exp});
   endtask
   task automatic next_manual(input string tag);
      int s = n_strobe;
      keys_n[0] = 1'b0;
      ticks($urandom_range(8, 12));
      keys_n[0] = 1'b1;
      ticks($urandom_range(8, 12));
      m_page = (m_page + 1) % 4;
      chk({tag, "_page"}, {126'b0, page}, 128'(m_page));
      chk({tag, "_value"}, {96'b0, state_value}, {96'b0, word(m_page)});
      chk({tag, "_strobes"}, 128'(n_strobe - s), 128'd1);
   endtask
   initial begin
      #600000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end
   initial begin
      set_debug(K);
      #2;
      chk("rst_value", {96'b0, state_value}, '0);
      chk("rst_page", {126'b0, page}, '0);
      chk("rst_auto", {127'b0, auto_mode}, '0);
      chk("rst_strobe", {127'b0, page_strobe}, '0);
      #10 rst_n = 1'b1;
      tick();
      chk("rst_lat1_value", {96'b0, state_value}, '0);
      tick();
      chk("rst_lat2_value", {96'b0, state_value}, {96'b0, K[31:0]});
      for (int i = 0; i < 4; i++) next_manual("wrap");
      s0 = n_strobe;
      repeat (5) begin
         keys_n[0] = 1'b0;
         ticks(2);
         keys_n[0] = 1'b1;
         ticks(2);
      end
      chk("bounce_page", {126'b0, page}, '0);
      chk("bounce_strobes", 128'(n_strobe - s0), '0);
      keys_n[0] = 1'b0;
      ticks(10);
      keys_n[0] = 1'b1;
      ticks(10);
      m_page = 1;
      chk("bounce_final_page", {126'b0, page}, 128'd1);
      chk("bounce_final_strobes", 128'(n_strobe - s0), 128'd1);
      keys_n[0] = 1'b0;
      s0 = n_cyc;
      wait_change("next_lat_timeout");
      lat = n_cyc - s0;
      chk("next_lat_debounced", {127'b0, lat > 4}, 128'd1);
      ticks(5);
      keys_n[0] = 1'b1;
      ticks(10);
      m_page = 2;
      chk("lat_page", {126'b0, page}, 128'd2);
      keys_n[1] = 1'b0;
      wait_auto(1'b1, "auto_enter");
      c0 = n_cyc;
      p0 = page;
      chk("auto_enter_page", {126'b0, page}, 128'd2);
      keys_n[1] = 1'b1;
      for (int i = 0; i < 4; i++) begin
         wait_change("auto_dwell_timeout");
         chk("auto_dwell_interval", 128'(n_cyc - c0), 128'd8);
         chk("auto_dwell_page", {126'b0, page}, {126'b0, p0 + 2'd1});
         c0 = n_cyc;
         p0 = page;
      end
      ticks(11 - lat);
      keys_n[0] = 1'b0;
      t0 = n_cyc + lat;
      wait_change("auto_pre_next_timeout");
      chk("auto_pre_next_interval", 128'(n_cyc - c0), 128'd8);
      p0 = page;
      wait_change("auto_next_timeout");
      chk("auto_next_time", 128'(n_cyc), 128'(t0));
      chk("auto_next_page", {126'b0, page}, {126'b0, p0 + 2'd1});
      keys_n[0] = 1'b1;
      p0 = page;
      wait_change("auto_restart_timeout");
      chk("auto_restart_interval", 128'(n_cyc - t0), 128'd8);
      chk("auto_restart_page", {126'b0, page}, {126'b0, p0 + 2'd1});
      keys_n[1] = 1'b0;
      wait_auto(1'b0, "auto_exit");
      p0 = page;
      keys_n[1] = 1'b1;
      ticks(20);
      chk("manual_page_kept", {126'b0, page}, {126'b0, p0});
      m_page = int'(page);
      while (m_page != 2) next_manual("to2");
      keys_n[1:0] = 2'b00;
      s0 = n_strobe;
      wait_change("simul_timeout");
      c0 = n_cyc;
      chk("simul_page", {126'b0, page}, 128'd3);
      chk("simul_auto", {127'b0, auto_mode}, 128'd1);
      keys_n[1:0] = 2'b11;
      tick();
      chk("simul_strobes", 128'(n_strobe - s0), 128'd1);
      wait_change("simul_dwell_timeout");
      chk("simul_dwell_interval", 128'(n_cyc - c0), 128'd8);
      chk("simul_dwell_page", {126'b0, page}, '0);
      keys_n[1] = 1'b0;
      wait_auto(1'b0, "simul_exit");
      keys_n[1] = 1'b1;
      ticks(12);
      m_page = int'(page);
      while (m_page != 0) next_manual("to0");
      m_a = {$urandom, $urandom, $urandom, $urandom};
      set_debug(m_a);
      ticks(3);
      keys_n[2] = 1'b0;
      ticks(10);
      m_hold = 1'b1;
      set_debug(~m_a);
      ticks(3);
      chk("hold_frozen", {96'b0, state_value}, {96'b0, m_a[31:0]});
      next_manual("hold_next");
      chk("hold_page1_of_a", {96'b0, state_value}, {96'b0, m_a[63:32]});
      keys_n[2] = 1'b1;
      ticks(10);
      m_hold = 1'b0;
      set_debug(debug);
      chk("hold_release_b", {96'b0, state_value}, {96'b0, word(1)});
      set_debug({$urandom, $urandom, $urandom, $urandom});
      tick();
      chk("debug_lat1_old", {96'b0, state_value}, {96'b0, ~m_a[63:32]});
      tick();
      chk("debug_lat2_new", {96'b0, state_value}, {96'b0, word(1)});
      repeat (6) begin
         set_debug({$urandom, $urandom, $urandom, $urandom});
         ticks(3);
         chk("rand_value", {96'b0, state_value}, {96'b0, word(m_page)});
         repeat ($urandom_range(0, 2)) next_manual("rand");
         keys_n[0] = 1'b0;
         ticks($urandom_range(1, 2));
         keys_n[0] = 1'b1;
         ticks(8);
         chk("rand_glitch_page", {126'b0, page}, 128'(m_page));
      end
      keys_n[1] = 1'b0;
      wait_auto(1'b1, "mid_auto_enter");
      keys_n[1] = 1'b1;
      set_debug(K);
      ticks(5);
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("mid_rst_value", {96'b0, state_value}, '0);
      chk("mid_rst_page", {126'b0, page}, '0);
      chk("mid_rst_auto", {127'b0, auto_mode}, '0);
      chk("mid_rst_strobe", {127'b0, page_strobe}, '0);
      #3 rst_n = 1'b1;
      tick();
      chk("mid_rst_lat1", {96'b0, state_value}, '0);
      tick();
      chk("mid_rst_lat2", {96'b0, state_value}, {96'b0, K[31:0]});
      ticks(12);
      chk("mid_rst_manual_page", {126'b0, page}, '0);
      chk("mid_rst_manual_auto", {127'b0, auto_mode}, '0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
